interp_operand_sequencer: RTL and testbench
===========================================

# interp_operand_sequencer

Parametrised successor to the single-cycle select mux. It walks the interpolation input block itself instead of decoding an external select. For each block it emits, in order, every integer-pel row, every integer-pel column, and every half-pel A/B/C vector to the 8-tap filter bank, using a valid/ready handshake. It sits between the block loader and the sub-pixel filter array; phases can be masked per block.

## Interface
- NUM_PIXEL, 8, output block edge N (pixels).
- TAPS, 8, filter length T; span S = N+T-1 (15 at defaults).
- PIXEL_W, 8, bits per pixel W.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a block; sampled only in IDLE.
- mode_mask  input  5  phase enables: bit0 rows, bit1 cols, bit2 half A, bit3 half B, bit4 half C.
- integer_array  input  S*S*W  row r pixel c at bit ((r*S)+c)*W.
- a_half_array, b_half_array, c_half_array  input  N*S*W each  vector i at bits [i*S*W +: S*W].
- out_valid  output  1  beat present.
- out_ready  input  1  filter accepts beat.
- out_data  output  S*W  operand vector; pixel k at [k*W +: W].
- out_kind  output  3  0 row, 1 col, 2 half A, 3 half B, 4 half C.
- out_index  output  8  row/column/vector index within phase.
- out_last  output  1  final beat of the block.
- busy  output  1  block in progress.
- done  output  1  one-cycle pulse at block end.

## Operation
- States: IDLE, ROWS, COLS, HALF_A, HALF_B, HALF_C, DONE.
- IDLE + start: mode_mask is latched, and the FSM enters the lowest enabled phase. If the mask is 0, it goes to DONE.
- Phase order is fixed: ROWS (S beats) -> COLS (S) -> HALF_A (N) -> HALF_B (N) -> HALF_C (N). Disabled phases are skipped with no idle cycle.
- ROWS beat i: out_data = integer row i.
- COLS beat i: out_data pixel k = integer row k, pixel i.
- HALF_x beat i: out_data = half_x vector i.
- Index counter runs 0..len-1 and clears on phase change. out_index is zero-extended.
- out_last = 1 on the final beat of the last enabled phase.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE, including in DONE. mode_mask changes while busy have no effect.
- Without capture (see Configuration), all array inputs must be held stable from start until done.

## Timing
- Reset values: out_valid 0, out_data 0, out_kind 0, out_index 0, out_last 0, busy 0, done 0. FSM is in IDLE and the counter is 0.
- All outputs are registered.
- start at edge 0 -> first beat valid at cycle 1; busy=1 from cycle 1 through the DONE cycle.
- A beat transfers on an edge where out_valid && out_ready. The next beat is valid the following cycle, so throughput is 1 beat/cycle with ready held high.
- While out_valid && !out_ready, out_data, out_kind, out_index and out_last hold stable.
- out_valid never drops without a transfer.
- Last beat transferred at edge k -> cycle k+1: out_valid=0, done=1. Cycle k+2: IDLE, busy=0, and a new start is accepted.
- Full mask at defaults: 54 beats; start to done = 55 cycles with ready always high.
- Reset asserted mid-block: immediate return to reset values; no done pulse.

## Configuration
- INTERP_SEQ_CAPTURE_EN defined: integer_array and the three half arrays are snapshotted into internal registers on the accepting start edge. Sources may change freely while busy; emitted data reflects the snapshot. Adds S*S*W + 3*N*S*W flops.
- Undefined: no snapshot; data is read live from the inputs, and the stability rule under Operation applies.

## Test plan
- Reset then start with mask 5'b11111, ready=1, integer pixel(r,c)=16r+c, half vectors = constants -> 54 beats. Beat 0 is row 0 (pixels 0..14). Beat 15 is column 0 (pixels 0,16,..,224). out_last on beat 53; done at cycle 55.
- Mask 5'b00010 -> exactly 15 COLS beats, kind=1, index 0..14, last on index 14.
- ready toggled 1,0,0,1 during ROWS -> data/index held during stall; no beat lost or duplicated.
- Mask 0 -> no out_valid; done at cycle 1 after start; busy high 1 cycle.
- start pulsed during ROWS and during DONE -> ignored; exactly one block emitted.
- Reset low at beat 7 -> outputs 0 immediately. A fresh start after release restarts at row 0.
- With INTERP_SEQ_CAPTURE_EN: change integer_array at cycle 2 -> all beats match the value present at start.

Source files
------------

// File: rtl/interp_operand_sequencer.sv
// Walks an interpolation block and streams row, column and half-pel A/B/C operand vectors to the filter bank.
// Optional macro INTERP_SEQ_CAPTURE_EN snapshots all source arrays on the accepting start edge.
module interp_operand_sequencer #(
    parameter int NUM_PIXEL = 8,
    parameter int TAPS      = 8,
    parameter int PIXEL_W   = 8
) (
    input  logic                                                                    clock,
    input  logic                                                                    reset,
    input  logic                                                                    start,
    input  logic [4:0]                                                              mode_mask,
    input  logic [(NUM_PIXEL+TAPS-1)*(NUM_PIXEL+TAPS-1)*PIXEL_W-1:0]                integer_array,
    input  logic [NUM_PIXEL*(NUM_PIXEL+TAPS-1)*PIXEL_W-1:0]                         a_half_array,
    input  logic [NUM_PIXEL*(NUM_PIXEL+TAPS-1)*PIXEL_W-1:0]                         b_half_array,
    input  logic [NUM_PIXEL*(NUM_PIXEL+TAPS-1)*PIXEL_W-1:0]                         c_half_array,
    output logic                                                                    out_valid,
    input  logic                                                                    out_ready,
    output logic [(NUM_PIXEL+TAPS-1)*PIXEL_W-1:0]                                   out_data,
    output logic [2:0]                                                              out_kind,
    output logic [7:0]                                                              out_index,
    output logic                                                                    out_last,
    output logic                                                                    busy,
    output logic                                                                    done
);
    localparam int S      = NUM_PIXEL + TAPS - 1;
    localparam int VEC_W  = S * PIXEL_W;
    localparam int INT_W  = S * VEC_W;
    localparam int HALF_W = NUM_PIXEL * VEC_W;
    localparam logic [2:0] NONE = 3'd7;

    // Phase states share their encoding with out_kind.
    typedef enum logic [2:0] {
        ROWS = 3'd0, COLS = 3'd1, HALF_A = 3'd2, HALF_B = 3'd3, HALF_C = 3'd4,
        IDLE = 3'd5, DONE = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [4:0]       mask_q, mask_d;
    logic             valid_d, last_d, busy_d, done_d;
    logic [2:0]       kind_d;
    logic [VEC_W-1:0] data_d;
    logic [2:0]       nk;
    logic [7:0]       ni;
    logic             go;
    logic [INT_W-1:0]  int_src;
    logic [HALF_W-1:0] a_src, b_src, c_src;

    function automatic logic [2:0] first_from(input logic [4:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = NONE;
        for (int j = 4; j >= 0; j--)
            if (m[j] && (3'(j) >= from)) r = 3'(j);
        return r;
    endfunction

    function automatic logic [7:0] last_index(input logic [2:0] kind);
        return (kind <= 3'd1) ? 8'(S - 1) : 8'(NUM_PIXEL - 1);
    endfunction

`ifdef INTERP_SEQ_CAPTURE_EN
    logic [INT_W-1:0]  int_q;
    logic [HALF_W-1:0] a_q, b_q, c_q;

    // NOTE: snapshot registers hold pure data and are always written before use, so they carry no reset.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && start) begin
            int_q <= integer_array;
            a_q   <= a_half_array;
            b_q   <= b_half_array;
            c_q   <= c_half_array;
        end
    end

    // The first beat is loaded on the snapshot edge itself, so IDLE reads the live inputs.
    assign int_src = (state_q == IDLE) ? integer_array : int_q;
    assign a_src   = (state_q == IDLE) ? a_half_array  : a_q;
    assign b_src   = (state_q == IDLE) ? b_half_array  : b_q;
    assign c_src   = (state_q == IDLE) ? c_half_array  : c_q;
`else
    assign int_src = integer_array;
    assign a_src   = a_half_array;
    assign b_src   = b_half_array;
    assign c_src   = c_half_array;
`endif

    always_comb begin
        data_d = '0;
        for (int k = 0; k < S; k++) begin
            case (nk)
                3'd0:    data_d[k*PIXEL_W +: PIXEL_W] = int_src[(int'(ni)*S + k)*PIXEL_W +: PIXEL_W];
                3'd1:    data_d[k*PIXEL_W +: PIXEL_W] = int_src[(k*S + int'(ni))*PIXEL_W +: PIXEL_W];
                3'd2:    data_d[k*PIXEL_W +: PIXEL_W] = a_src[(int'(ni)*S + k)*PIXEL_W +: PIXEL_W];
                3'd3:    data_d[k*PIXEL_W +: PIXEL_W] = b_src[(int'(ni)*S + k)*PIXEL_W +: PIXEL_W];
                3'd4:    data_d[k*PIXEL_W +: PIXEL_W] = c_src[(int'(ni)*S + k)*PIXEL_W +: PIXEL_W];
                default: data_d[k*PIXEL_W +: PIXEL_W] = '0;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        valid_d = out_valid;
        last_d  = out_last;
        kind_d  = out_kind;
        busy_d  = busy;
        done_d  = 1'b0;
        nk      = NONE;
        ni      = '0;
        go      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d = mode_mask;
                    nk     = first_from(mode_mask, 3'd0);
                    go     = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                if (out_valid && out_ready) begin
                    go = 1'b1;
                    if (idx_q == last_index(state_q)) begin
                        nk = first_from(mask_q, 3'(state_q) + 3'd1);
                    end else begin
                        nk = 3'(state_q);
                        ni = idx_q + 8'd1;
                    end
                end
            end
        endcase

        if (go) begin
            busy_d = 1'b1;
            if (nk == NONE) begin
                state_d = DONE;
                idx_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = state_t'(nk);
                idx_d   = ni;
                valid_d = 1'b1;
                kind_d  = nk;
                last_d  = (ni == last_index(nk)) && (first_from(mask_d, nk + 3'd1) == NONE);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mask_q    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_kind  <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            out_kind  <= kind_d;
            if (go && nk != NONE) out_data <= data_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign out_index = idx_q;

endmodule

// File: tb/tb_interp_operand_sequencer.sv
// Directed bench for interp_operand_sequencer: full walk, masked phases, stalls, ignored starts, mid-block reset.
module tb_interp_operand_sequencer;
    localparam int N = 8;
    localparam int T = 8;
    localparam int W = 8;
    localparam int S = N + T - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             out_ready = 1'b0;
    logic [4:0]       mode_mask = 5'd0;
    logic [S*S*W-1:0] integer_array;
    logic [N*S*W-1:0] a_half_array, b_half_array, c_half_array;
    logic             out_valid, out_last, busy, done;
    logic [S*W-1:0]   out_data;
    logic [2:0]       out_kind;
    logic [7:0]       out_index;

    int errors = 0;
    int checks = 0;

    interp_operand_sequencer #(.NUM_PIXEL(N), .TAPS(T), .PIXEL_W(W)) dut (
        .clock(clock), .reset(reset), .start(start), .mode_mask(mode_mask),
        .integer_array(integer_array), .a_half_array(a_half_array),
        .b_half_array(b_half_array), .c_half_array(c_half_array),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_kind(out_kind), .out_index(out_index), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected vector straight from the stimulus formulas: pixel(r,c)=16r+c, half vector i = base+i.
    function automatic logic [S*W-1:0] exp_data(input int kind, input int idx);
        logic [S*W-1:0] v;
        v = '0;
        for (int k = 0; k < S; k++) begin
            case (kind)
                0:       v[k*W +: W] = 8'(16*idx + k);
                1:       v[k*W +: W] = 8'(16*k + idx);
                2:       v[k*W +: W] = 8'(8'h40 + idx);
                3:       v[k*W +: W] = 8'(8'h60 + idx);
                default: v[k*W +: W] = 8'(8'h80 + idx);
            endcase
        end
        return v;
    endfunction

    task automatic run_block(input logic [4:0] mask, input bit stall, input bit poke, input int exp_done);
        int  kinds[$];
        int  idxs[$];
        int  pos = 0;
        int  cycle;
        bit  finished = 1'b0;
        bit  prev_stall = 1'b0;
        bit  flipped = 1'b0;
        for (int ph = 0; ph < 5; ph++)
            if (mask[ph])
                for (int i = 0; i < ((ph < 2) ? S : N); i++) begin
                    kinds.push_back(ph);
                    idxs.push_back(i);
                end
        mode_mask = mask;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start     = 1'b0;
        mode_mask = 5'd0;
        cycle     = 1;
        while (!finished && cycle < 200) begin
            out_ready = !(stall && (cycle == 2 || cycle == 3));
            start     = poke && (cycle == 3);
`ifdef INTERP_SEQ_CAPTURE_EN
            if (cycle == 2) begin
                integer_array = ~integer_array;
                flipped = 1'b1;
            end
`endif
            if (prev_stall) check("valid_hold", out_valid, 1);
            if (out_valid) begin
                if (pos < kinds.size()) begin
                    check("beat_data", out_data, exp_data(kinds[pos], idxs[pos]));
                    check("beat_meta", {out_kind, out_index, out_last},
                          {3'(kinds[pos]), 8'(idxs[pos]), 1'(pos == kinds.size() - 1)});
                end else begin
                    check("extra_beat", out_valid, 0);
                end
                if (out_ready) pos++;
            end
            prev_stall = out_valid && !out_ready;
            check("busy_in_block", busy, 1);
            if (done) begin
                finished = 1'b1;
                check("done_cycle", cycle, exp_done);
                check("beats_sent", pos, kinds.size());
                check("valid_at_done", out_valid, 0);
                start = poke;
                step();
                start = 1'b0;
                check("idle_after_done", {busy, done, out_valid}, 3'b000);
            end else begin
                step();
                cycle++;
            end
        end
        if (!finished) check("done_timeout", done, 1);
        start = 1'b0;
        if (flipped) integer_array = ~integer_array;
        step();
        check("still_idle", busy, 0);
    endtask

    initial begin
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++)
                integer_array[(r*S + c)*W +: W] = 8'(16*r + c);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < S; k++) begin
                a_half_array[(i*S + k)*W +: W] = 8'(8'h40 + i);
                b_half_array[(i*S + k)*W +: W] = 8'(8'h60 + i);
                c_half_array[(i*S + k)*W +: W] = 8'(8'h80 + i);
            end

        #1 reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check("reset_ctrl", {out_valid, out_kind, out_index, out_last, busy, done}, 15'd0);
        check("reset_data", out_data, 0);

        run_block(5'b11111, 1'b0, 1'b0, 55);
        run_block(5'b00010, 1'b0, 1'b0, 16);
        run_block(5'b00001, 1'b1, 1'b1, 18);
        run_block(5'b00000, 1'b0, 1'b0, 1);
        run_block(5'b10100, 1'b0, 1'b0, 17);

        mode_mask = 5'b11111;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start     = 1'b0;
        mode_mask = 5'd0;
        repeat (7) step();
        check("pre_reset_index", out_index, 7);
        #2 reset = 1'b0;
        #1;
        check("midreset_ctrl", {out_valid, out_kind, out_index, out_last, busy, done}, 15'd0);
        check("midreset_data", out_data, 0);
        step();
        step();
        check("no_done_in_reset", done, 0);
        reset = 1'b1;
        step();
        run_block(5'b00001, 1'b0, 1'b0, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
